// File: rtl/parity_frame_pkg.sv
// Shared definitions for the serial parity frame receiver and its sibling parity generator.
package parity_frame_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DATA      = 3'd1;
  localparam logic [2:0] ST_PARITY    = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  // Start, parity and stop bits surround the data bits of every frame.
  localparam int unsigned FRAME_OVERHEAD = 3;
  localparam int unsigned MAX_DATA_W     = 16;

  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + FRAME_OVERHEAD;
  endfunction

  // Parity bit a transmitter places after the data; zero-extension does not change it.
  function automatic logic exp_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_rx_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then increment unless already at full scale.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: deframes start/data/parity/stop sampled on bit_en and
// reports the word with reduction flags, parity/framing status and an error count.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              all_ones,
  output logic              any_one,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = $clog2(frame_len(DATA_W));

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              p_rx_q, p_rx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              all_ones_q, all_ones_d;
  logic              any_one_q, any_one_d;
  logic              busy_q, busy_d;
  logic              err_inc_s;
  logic              parity_bad_s;

  assign parity_bad_s = p_rx_q ^ exp_parity(MAX_DATA_W'(shift_q), 1'(ODD_PARITY));

  // Frame FSM, shift register and result capture; everything holds without bit_en.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_rx_d       = p_rx_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    all_ones_d   = all_ones_q;
    any_one_d    = any_one_q;
    err_inc_s    = 1'b0;
    if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == IDX_W'(i)) begin
              shift_d[i] = rx;
            end
          end
          if (bit_cnt_q == IDX_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        ST_PARITY: begin
          p_rx_d  = rx;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          data_d       = shift_q;
          all_ones_d   = &shift_q;
          any_one_d    = |shift_q;
          parity_err_d = parity_bad_s;
          frame_err_d  = ~rx;
          valid_d      = 1'b1;
          err_inc_s    = parity_bad_s | ~rx;
          state_d      = rx ? ST_IDLE : ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          state_d = rx ? ST_IDLE : ST_WAIT_HIGH;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_rx_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      all_ones_q   <= 1'b0;
      any_one_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_rx_q       <= p_rx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      all_ones_q   <= all_ones_d;
      any_one_q    <= any_one_d;
      busy_q       <= busy_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc_s),
    .clr   (clr_cnt),
    .cnt   (err_cnt)
  );

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign all_ones   = all_ones_q;
  assign any_one    = any_one_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity/2-bit-counter and an odd-parity/8-bit-counter
// instance share one serial stream; per-frame expectations go through a scoreboard queue.
module tb_parity_frame_rx;

  logic clk, rst_n, bit_en, rx, clr_cnt;
  logic [3:0] data_e, data_o;
  logic valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o;
  logic all_e, all_o, any_e, any_o, busy_e, busy_o;
  logic [1:0] cnt_e;
  logic [7:0] cnt_o;

  parity_frame_rx #(.DATA_W(4), .ODD_PARITY(0), .CNT_W(2)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx), .clr_cnt(clr_cnt),
    .data(data_e), .valid(valid_e), .parity_err(perr_e), .frame_err(ferr_e),
    .all_ones(all_e), .any_one(any_e), .busy(busy_e), .err_cnt(cnt_e));

  parity_frame_rx #(.DATA_W(4), .ODD_PARITY(1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx), .clr_cnt(clr_cnt),
    .data(data_o), .valid(valid_o), .parity_err(perr_o), .frame_err(ferr_o),
    .all_ones(all_o), .any_one(any_o), .busy(busy_o), .err_cnt(cnt_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       p;
    logic       s;
    logic       perr_e;
    logic       perr_o;
    logic       ferr;
    logic       all1;
    logic       any1;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic       perr_e;
    logic       perr_o;
    logic       ferr;
    logic       all1;
    logic       any1;
    logic [1:0] cnt_e;
    logic [7:0] cnt_o;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  logic [1:0] m_cnt_e = 2'd0;
  logic [7:0] m_cnt_o = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (valid_e === 1'b1 || valid_o === 1'b1)) begin
      nvalid++;
      chk("valid_pair", 32'(valid_o), 32'(valid_e));
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid_e), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("data_e", 32'(data_e), 32'(x.data));
        chk("data_o", 32'(data_o), 32'(x.data));
        chk("perr_e", 32'(perr_e), 32'(x.perr_e));
        chk("perr_o", 32'(perr_o), 32'(x.perr_o));
        chk("ferr_e", 32'(ferr_e), 32'(x.ferr));
        chk("ferr_o", 32'(ferr_o), 32'(x.ferr));
        chk("all_ones", 32'(all_e), 32'(x.all1));
        chk("any_one", 32'(any_e), 32'(x.any1));
        chk("err_cnt_e", 32'(cnt_e), 32'(x.cnt_e));
        chk("err_cnt_o", 32'(cnt_o), 32'(x.cnt_o));
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    rx = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx = ~b;
      tick();
    end
  endtask

  task automatic send_frame(input vec_t v, input int gap, input logic clr_at_stop);
    exp_t x;
    send_bit(1'b0, gap);
    for (int i = 0; i < 4; i++) send_bit(v.d[i], gap);
    send_bit(v.p, gap);
    if (clr_at_stop) begin
      m_cnt_e = 2'd0;
      m_cnt_o = 8'd0;
    end else begin
      if ((v.perr_e | v.ferr) && m_cnt_e != 2'd3) m_cnt_e = m_cnt_e + 2'd1;
      if ((v.perr_o | v.ferr) && m_cnt_o != 8'hFF) m_cnt_o = m_cnt_o + 8'd1;
    end
    x.data = v.d; x.perr_e = v.perr_e; x.perr_o = v.perr_o; x.ferr = v.ferr;
    x.all1 = v.all1; x.any1 = v.any1; x.cnt_e = m_cnt_e; x.cnt_o = m_cnt_o;
    sb.push_back(x);
    rx = v.s;
    bit_en = 1'b1;
    clr_cnt = clr_at_stop;
    tick();
    bit_en = 1'b0;
    clr_cnt = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx = ~v.s;
      tick();
    end
    rx = v.s;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, 32'(data_e), 32'd0);
    chk({tag, "_valid"}, 32'(valid_e), 32'd0);
    chk({tag, "_perr"}, 32'(perr_e), 32'd0);
    chk({tag, "_ferr"}, 32'(ferr_e), 32'd0);
    chk({tag, "_all"}, 32'(all_e), 32'd0);
    chk({tag, "_any"}, 32'(any_e), 32'd0);
    chk({tag, "_busy"}, 32'(busy_e), 32'd0);
    chk({tag, "_cnt_e"}, 32'(cnt_e), 32'd0);
    chk({tag, "_cnt_o"}, 32'(cnt_o), 32'd0);
    chk({tag, "_data_o"}, 32'(data_o), 32'd0);
  endtask

  vec_t tbl[5];
  vec_t v;
  int nv0;

  initial begin
    //            d        p     s     perr_e perr_o ferr  all1  any1
    tbl[0] = '{4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; bit_en = 1'b0; rx = 1'b1; clr_cnt = 1'b0;
    tick(); tick();
    check_reset("por");
    rst_n = 1'b1;
    tick();

    // Back-to-back frames: each start bit follows the previous good stop bit directly.
    for (int i = 0; i < 5; i++) send_frame(tbl[i], 0, 1'b0);
    tick();

    // Stop bit low: one valid, then the held-low line must not start a new frame.
    nv0 = nvalid;
    v = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    send_frame(v, 0, 1'b0);
    chk("wait_busy0", 32'(busy_e), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 0);
      chk("wait_busy", 32'(busy_e), 32'd1);
    end
    send_bit(1'b1, 0);
    chk("wait_exit_busy", 32'(busy_e), 32'd0);
    tick();
    chk("wait_single_valid", 32'(nvalid - nv0), 32'd1);

    // Strobe every third clock with rx toggled between strobes.
    send_frame(tbl[0], 2, 1'b0);
    tick();

    // Reset after two data bits discards the partial frame.
    send_bit(1'b0, 0);
    chk("busy_after_start", 32'(busy_e), 32'd1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    rst_n = 1'b0;
    tick();
    check_reset("mid");
    m_cnt_e = 2'd0;
    m_cnt_o = 8'd0;
    rst_n = 1'b1;
    rx = 1'b1;
    tick(); tick();
    v = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    send_frame(v, 0, 1'b0);
    tick();

    // Saturation of the 2-bit counter, then clear colliding with an increment.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    m_cnt_e = 2'd0;
    m_cnt_o = 8'd0;
    chk("clr_cnt_e", 32'(cnt_e), 32'd0);
    chk("clr_cnt_o", 32'(cnt_o), 32'd0);
    for (int i = 0; i < 5; i++) send_frame(tbl[1], 0, 1'b0);
    chk("sat_cnt_e", 32'(cnt_e), 32'd3);
    send_frame(tbl[1], 0, 1'b1);
    chk("clr_wins_e", 32'(cnt_e), 32'd0);
    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
